// File: rtl/iodelay_pkg.sv
// rtl/iodelay_pkg.sv - shared types and constants for the IDELAYCTRL reset/calibration sequencer
package iodelay_pkg;

    typedef enum logic [1:0] {
        e_iod_hold,
        e_iod_wait,
        e_iod_locked,
        e_iod_fail
    } iodelay_state_e;

    // 16 cycles at 200 MHz = 80 ns, comfortably above the IDELAYCTRL minimum reset pulse
    localparam int iod_hold_cycles_default = 16;

endpackage

// File: rtl/iodelay_rdy_sync.sv
// rtl/iodelay_rdy_sync.sv - multi-stage synchronizer for the asynchronous IDELAYCTRL RDY bits
module iodelay_rdy_sync #(
    parameter int width_p       = 1,
    parameter int sync_stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

`ifdef FPGA
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [width_p-1:0] stage_r [sync_stages_p];
`else
    logic [width_p-1:0] stage_r [sync_stages_p];
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < sync_stages_p; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d_i;
            for (int i = 1; i < sync_stages_p; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q_o = stage_r[sync_stages_p-1];

endmodule

// File: rtl/iodelay_ctrl_sequencer.sv
// rtl/iodelay_ctrl_sequencer.sv - reset/calibration sequencer with timeout, bounded retries and relock
module iodelay_ctrl_sequencer
    import iodelay_pkg::*;
#(
    parameter int num_banks_p   = 1,
    parameter int hold_cycles_p = iod_hold_cycles_default,
    parameter int sync_stages_p = 2,
    parameter int timeout_p     = 1024,
    parameter int max_retries_p = 3
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               soft_reset_i,
    input  logic [num_banks_p-1:0]             rdy_i,
    output logic [num_banks_p-1:0]             idelayctrl_rst_o,
    output logic [num_banks_p-1:0]             bank_rdy_o,
    output logic                               ready_o,
    output logic                               error_o,
    output logic [$clog2(max_retries_p+1)-1:0] retry_count_o
);

    localparam int cnt_w_lp   = $clog2((hold_cycles_p > timeout_p) ? hold_cycles_p : timeout_p);
    localparam int retry_w_lp = $clog2(max_retries_p + 1);

    localparam logic [cnt_w_lp-1:0]   hold_last_lp    = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0]   timeout_last_lp = cnt_w_lp'(timeout_p - 1);
    localparam logic [retry_w_lp-1:0] retry_max_lp    = retry_w_lp'(max_retries_p);

    iodelay_state_e        state_r, state_d;
    logic [cnt_w_lp-1:0]   cnt_r, cnt_d;
    logic [retry_w_lp-1:0] retry_r, retry_d, retry_inc;
    logic                  all_rdy;

    iodelay_rdy_sync #(
        .width_p       (num_banks_p),
        .sync_stages_p (sync_stages_p)
    ) u_rdy_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (rdy_i),
        .q_o       (bank_rdy_o)
    );

    assign all_rdy   = &bank_rdy_o;
    assign retry_inc = retry_r + retry_w_lp'(1);

    // Counter only runs in HOLD/WAIT and is cleared on every transition, so it never wraps.
    always_comb begin
        state_d = state_r;
        cnt_d   = cnt_r + cnt_w_lp'(1);
        retry_d = retry_r;
        if (soft_reset_i) begin
            state_d = e_iod_hold;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_r)
                e_iod_hold: begin
                    if (cnt_r == hold_last_lp) begin
                        state_d = e_iod_wait;
                        cnt_d   = '0;
                    end
                end
                e_iod_wait: begin
                    if (all_rdy) begin
                        state_d = e_iod_locked;
                        cnt_d   = '0;
                    end else if (cnt_r == timeout_last_lp) begin
                        cnt_d = '0;
                        if (retry_r != retry_max_lp) begin
                            retry_d = retry_inc;
                        end
                        state_d = (retry_inc >= retry_max_lp) ? e_iod_fail : e_iod_hold;
                    end
                end
                e_iod_locked: begin
                    cnt_d = '0;
                    if (!all_rdy) begin
                        state_d = e_iod_hold;
                    end
                end
                e_iod_fail: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = e_iod_hold;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r          <= e_iod_hold;
            cnt_r            <= '0;
            retry_r          <= '0;
            idelayctrl_rst_o <= '1;
            ready_o          <= 1'b0;
            error_o          <= 1'b0;
        end else begin
            state_r          <= state_d;
            cnt_r            <= cnt_d;
            retry_r          <= retry_d;
            idelayctrl_rst_o <= {num_banks_p{(state_d == e_iod_hold) || (state_d == e_iod_fail)}};
            ready_o          <= (state_d == e_iod_locked);
            error_o          <= (state_d == e_iod_fail);
        end
    end

    assign retry_count_o = retry_r;

endmodule

// File: tb/tb_iodelay_ctrl_sequencer.sv
// tb/tb_iodelay_ctrl_sequencer.sv - scoreboard bench for iodelay_ctrl_sequencer
module tb_iodelay_ctrl_sequencer;

    localparam int banks_lp   = 2;
    localparam int hold_lp    = 16;
    localparam int sync_lp    = 2;
    localparam int timeout_lp = 64;
    localparam int retries_lp = 3;
    localparam int attempt_lp = hold_lp + timeout_lp;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                soft_reset = 1'b0;
    logic [banks_lp-1:0] rdy = '0;
    logic [banks_lp-1:0] rst_out;
    logic [banks_lp-1:0] bank_rdy;
    logic                ready;
    logic                error;
    logic [1:0]          retry_count;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    iodelay_ctrl_sequencer #(
        .num_banks_p   (banks_lp),
        .hold_cycles_p (hold_lp),
        .sync_stages_p (sync_lp),
        .timeout_p     (timeout_lp),
        .max_retries_p (retries_lp)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .soft_reset_i     (soft_reset),
        .rdy_i            (rdy),
        .idelayctrl_rst_o (rst_out),
        .bank_rdy_o       (bank_rdy),
        .ready_o          (ready),
        .error_o          (error),
        .retry_count_o    (retry_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic edges_until_rst_low(output int n);
        n = 0;
        while (rst_out !== '0 && n < 500) begin
            step(1);
            n++;
        end
    endtask

    task automatic edges_until_ready(input logic v, output int n);
        n = 0;
        while (ready !== v && n < 500) begin
            step(1);
            n++;
        end
    endtask

    task automatic edges_until_retry_change(output int n);
        logic [1:0] old;
        old = retry_count;
        n = 0;
        while (retry_count === old && n < 500) begin
            step(1);
            n++;
        end
    endtask

    task automatic restart();
        rdy        = '0;
        soft_reset = 1'b0;
        reset_n    = 1'b0;
        step(1);
        reset_n    = 1'b1;
    endtask

    task automatic test_reset();
        rdy = '1;
        step(3);
        checks++; if (rst_out !== 2'b11) begin $display("FAIL reset_rst: got %b expected 11", rst_out); errors++; end
        checks++; if (ready !== 1'b0) begin $display("FAIL reset_ready: got %b expected 0", ready); errors++; end
        checks++; if (error !== 1'b0) begin $display("FAIL reset_error: got %b expected 0", error); errors++; end
        checks++; if (bank_rdy !== 2'b00) begin $display("FAIL reset_bank_rdy: got %b expected 00", bank_rdy); errors++; end
        checks++; if (retry_count !== 2'd0) begin $display("FAIL reset_retry: got %0d expected 0", retry_count); errors++; end
        rdy = '0;
    endtask

    task automatic test_lock();
        int   n;
        exp_t e;
        reset_n = 1'b1;
        push("hold_len", hold_lp);
        edges_until_rst_low(n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
        step(13);
        rdy = 2'b11;
        push("lock_latency", sync_lp + 1);
        edges_until_ready(1'b1, n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
        checks++; if (retry_count !== 2'd0) begin $display("FAIL lock_retry: got %0d expected 0", retry_count); errors++; end
        checks++; if (rst_out !== 2'b00) begin $display("FAIL lock_rst: got %b expected 00", rst_out); errors++; end
    endtask

    task automatic test_timeout_retries();
        int   n;
        exp_t e;
        restart();
        for (int i = 1; i <= retries_lp; i++) begin
            push($sformatf("attempt_len_%0d", i), attempt_lp);
            push($sformatf("retry_value_%0d", i), i);
            edges_until_retry_change(n);
            e = sb.pop_front();
            checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
            e = sb.pop_front();
            checks++; if (int'(retry_count) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, retry_count, e.val); errors++; end
        end
        checks++; if (error !== 1'b1) begin $display("FAIL fail_error: got %b expected 1", error); errors++; end
        checks++; if (rst_out !== 2'b11) begin $display("FAIL fail_rst: got %b expected 11", rst_out); errors++; end
        rdy = 2'b11;
        step(100);
        checks++; if (error !== 1'b1 || ready !== 1'b0) begin $display("FAIL fail_sticky: got error=%b ready=%b expected error=1 ready=0", error, ready); errors++; end
        checks++; if (retry_count !== 2'd3) begin $display("FAIL fail_retry_sat: got %0d expected 3", retry_count); errors++; end
    endtask

    task automatic test_soft_reset_from_fail();
        int   n;
        exp_t e;
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        checks++; if (error !== 1'b0) begin $display("FAIL soft_error: got %b expected 0", error); errors++; end
        checks++; if (retry_count !== 2'd0) begin $display("FAIL soft_retry: got %0d expected 0", retry_count); errors++; end
        checks++; if (rst_out !== 2'b11) begin $display("FAIL soft_rst: got %b expected 11", rst_out); errors++; end
        push("soft_relock_latency", hold_lp + 1);
        edges_until_ready(1'b1, n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
    endtask

    task automatic test_rdy_drop();
        int   n;
        int   m;
        exp_t e;
        rdy = 2'b01;
        push("drop_latency", sync_lp + 1);
        step(1);
        rdy = 2'b11;
        edges_until_ready(1'b0, m);
        n = m + 1;
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
        push("drop_hold_len", hold_lp);
        edges_until_rst_low(n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
        push("drop_relock", 1);
        edges_until_ready(1'b1, n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
        checks++; if (retry_count !== 2'd0) begin $display("FAIL drop_retry: got %0d expected 0", retry_count); errors++; end
    endtask

    task automatic test_async_reset();
        int   n;
        exp_t e;
        restart();
        step(100);
        checks++; if (retry_count !== 2'd1 || rst_out !== 2'b00) begin $display("FAIL async_pre: got retry=%0d rst=%b expected retry=1 rst=00", retry_count, rst_out); errors++; end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (rst_out !== 2'b11 || ready !== 1'b0) begin $display("FAIL async_outputs: got rst=%b ready=%b expected rst=11 ready=0", rst_out, ready); errors++; end
        checks++; if (retry_count !== 2'd0) begin $display("FAIL async_retry: got %0d expected 0", retry_count); errors++; end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push("async_hold_len", hold_lp);
        edges_until_rst_low(n);
        e = sb.pop_front();
        checks++; if (n !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, n, e.val); errors++; end
    endtask

    task automatic test_timeout_boundary();
        exp_t e;
        restart();
        step(attempt_lp - 3);
        rdy = 2'b11;
        push("boundary_ready", 1);
        push("boundary_retry", 0);
        step(3);
        e = sb.pop_front();
        checks++; if (int'(ready) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, ready, e.val); errors++; end
        e = sb.pop_front();
        checks++; if (int'(retry_count) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, retry_count, e.val); errors++; end

        restart();
        step(attempt_lp - 2);
        rdy = 2'b11;
        push("late_ready", 0);
        push("late_retry", 1);
        step(2);
        e = sb.pop_front();
        checks++; if (int'(ready) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, ready, e.val); errors++; end
        e = sb.pop_front();
        checks++; if (int'(retry_count) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, retry_count, e.val); errors++; end

        restart();
        step(attempt_lp - 3);
        rdy = 2'b11;
        step(2);
        soft_reset = 1'b1;
        push("soft_boundary_rst", 3);
        push("soft_boundary_ready", 0);
        step(1);
        soft_reset = 1'b0;
        e = sb.pop_front();
        checks++; if (int'(rst_out) !== e.val) begin $display("FAIL %s: got %0d expected %0d", e.tag, rst_out, e.val); errors++; end
        e = sb.pop_front();
        checks++; if (int'(ready) !== e.val || retry_count !== 2'd0) begin $display("FAIL %s: got ready=%0d retry=%0d expected ready=%0d retry=0", e.tag, ready, retry_count, e.val); errors++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_timeout_retries();
        test_soft_reset_from_fail();
        test_rdy_drop();
        test_async_reset();
        test_timeout_boundary();
        checks++; if (sb.size() != 0) begin $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); errors++; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
